// File: rtl/press_count_display.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : press_count_display
// Purpose  : Counts debounced switch releases as BCD 00..MAX_COUNT and drives
//            two active-low seven-segment digits. Optional auto-repeat while
//            held, enabled by macro PRESS_COUNT_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module press_count_display #(
   parameter int HOLD_CYCLES   = 12_500_000,
   parameter int REPEAT_CYCLES = 2_500_000,
   parameter int MAX_COUNT     = 99
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_Switch,
   output logic [7:0] o_Count,
   output logic       o_Wrap,
   output logic [6:0] o_Seg_Tens,
   output logic [6:0] o_Seg_Ones
);

   localparam logic [7:0] c_MAX_BCD   = {4'(MAX_COUNT / 10), 4'(MAX_COUNT % 10)};
   localparam logic [6:0] c_SEG_ZERO  = 7'b1000000;

`ifdef PRESS_COUNT_AUTOREPEAT_EN
   localparam logic [23:0] c_HOLD_LAST = 24'(HOLD_CYCLES - 1);
   localparam logic [23:0] c_REP_LAST  = 24'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HELD   = 2'd1,
      S_REPEAT = 2'd2
   } state_t;

   logic [23:0] r_Timer;
   logic        w_Timer_Clr;
`else
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HELD   = 2'd1
   } state_t;

   logic w_unused_cfg;
   assign w_unused_cfg = (HOLD_CYCLES != 0) ^ (REPEAT_CYCLES != 0);
`endif

   state_t r_State, w_Next_State;
   logic   r_Switch;
   logic   w_Press, w_Release, w_Inc;

   assign w_Press   = ~r_Switch &  i_Switch;
   assign w_Release =  r_Switch & ~i_Switch;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_Switch <= 1'b0;
         r_State  <= S_IDLE;
      end else begin
         r_Switch <= i_Switch;
         r_State  <= w_Next_State;
      end
   end

   always_comb begin
      w_Next_State = r_State;
      w_Inc        = 1'b0;
`ifdef PRESS_COUNT_AUTOREPEAT_EN
      w_Timer_Clr  = 1'b0;
`endif
      case (r_State)
         S_IDLE: begin
            if (w_Press) begin
               w_Next_State = S_HELD;
`ifdef PRESS_COUNT_AUTOREPEAT_EN
               w_Timer_Clr  = 1'b1;
`endif
            end
         end
         S_HELD: begin
            // A release wins over a coincident hold expiry: one increment only.
            if (w_Release) begin
               w_Inc        = 1'b1;
               w_Next_State = S_IDLE;
            end
`ifdef PRESS_COUNT_AUTOREPEAT_EN
            else if (r_Timer == c_HOLD_LAST) begin
               w_Inc        = 1'b1;
               w_Timer_Clr  = 1'b1;
               w_Next_State = S_REPEAT;
            end
`endif
         end
`ifdef PRESS_COUNT_AUTOREPEAT_EN
         S_REPEAT: begin
            if (r_Timer == c_REP_LAST) begin
               w_Inc       = 1'b1;
               w_Timer_Clr = 1'b1;
            end
            if (w_Release) begin
               w_Next_State = S_IDLE;
            end
         end
`endif
         default: w_Next_State = S_IDLE;
      endcase
   end

`ifdef PRESS_COUNT_AUTOREPEAT_EN
   always_ff @(posedge i_Clk) begin
      if (i_Rst || w_Timer_Clr || (r_State == S_IDLE)) begin
         r_Timer <= 24'd0;
      end else if (r_Timer != 24'hFF_FFFF) begin
         r_Timer <= r_Timer + 24'd1;
      end
   end
`endif

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         o_Count <= 8'h00;
         o_Wrap  <= 1'b0;
      end else begin
         o_Wrap <= 1'b0;
         if (w_Inc) begin
            if (o_Count == c_MAX_BCD) begin
               o_Count <= 8'h00;
               o_Wrap  <= 1'b1;
            end else if (o_Count[3:0] == 4'd9) begin
               o_Count <= {o_Count[7:4] + 4'd1, 4'd0};
            end else begin
               o_Count <= {o_Count[7:4], o_Count[3:0] + 4'd1};
            end
         end
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] digit);
      case (digit)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         o_Seg_Tens <= c_SEG_ZERO;
         o_Seg_Ones <= c_SEG_ZERO;
      end else begin
         o_Seg_Tens <= seg7(o_Count[7:4]);
         o_Seg_Ones <= seg7(o_Count[3:0]);
      end
   end

endmodule
`default_nettype wire

// File: doc/press_count_display.md
# press_count_display

Press counter and two-digit seven-segment driver that sits directly downstream of the switch debouncer. It consumes the debounced switch level, detects each release (high-to-low transition), and keeps a BCD count 00–99. It drives active-low segment patterns for a tens digit and a ones digit. An optional auto-repeat mode adds increments while the switch is held.

## Interface
- HOLD_CYCLES, 12_500_000: cycles the switch must stay high before the first auto-repeat increment (0.5 s at 25 MHz).
- REPEAT_CYCLES, 2_500_000: cycles between subsequent auto-repeat increments.
- MAX_COUNT, 99: highest count value, in decimal. Legal range 1–99. The count wraps to 0 after it.
- i_Clk  in  1  system clock; all logic is on its rising edge.
- i_Rst  in  1  reset; synchronous, active-high.
- i_Switch  in  1  debounced switch level from the debouncer; 1 = pressed.
- o_Count  out  8  current count as BCD; [7:4] is tens, [3:0] is ones.
- o_Wrap  out  1  one-cycle pulse when the count wraps from MAX_COUNT to 00.
- o_Seg_Tens  out  7  tens-digit segments, active low; bit0 = A … bit6 = G.
- o_Seg_Ones  out  7  ones-digit segments, same encoding as o_Seg_Tens.

## Operation
- A registered copy of i_Switch (r_Switch, reset value 0) provides edge detection.
  - A release is r_Switch==1 and i_Switch==0 in the same cycle.
  - A press is r_Switch==0 and i_Switch==1 in the same cycle.
- Increment rules:
  - When the ones digit is 9, it rolls to 0 and the tens digit increments.
  - When the count equals MAX_COUNT, an increment sets the count to 00 and pulses o_Wrap.
- State machine:
  - IDLE: the switch is released. A press moves to HELD and clears the timer.
  - HELD: the switch is held.
    - A release increments the count and moves to IDLE.
    - With auto-repeat compiled in: when the timer reaches HOLD_CYCLES-1, increment, clear the timer, and move to REPEAT.
  - REPEAT: every REPEAT_CYCLES cycles, increment and clear the timer. A release moves to IDLE without an increment.
- Timer: 24-bit, saturating. It is idle (held at 0) in IDLE.
- Segment encoding (active low, written G..A):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Non-BCD codes display blank (1111111).
- Leading zero is shown; 07 displays as "07".

## Timing
- Reset values: count 00, o_Wrap 0, r_Switch 0, state IDLE, timer 0. Both segment outputs are 1000000 ("0").
- Reset takes priority over any increment in the same cycle.
- If i_Switch is high when reset deasserts, the next cycle sees a press and the block enters HELD. A later release counts normally.
- Count latency: o_Count updates at the same rising edge at which the release (or timer expiry) condition is sampled.
- o_Wrap is asserted for exactly that one cycle.
- Segment latency: o_Seg_Tens and o_Seg_Ones are registered from o_Count and lag it by one cycle.
- At most one increment per cycle. If a timer expiry and a release coincide, only one increment occurs.
  - In HELD, the release increment applies.
  - In REPEAT, the expiry increment applies and the state returns to IDLE.
- Single-cycle pulses on i_Switch (high for one cycle) are counted. Filtering them is the debouncer's job.

## Configuration
- Macro: PRESS_COUNT_AUTOREPEAT_EN.
- Defined: HELD and REPEAT behave as described, including the timer-expiry increments.
- Undefined:
  - The REPEAT state and the timer are not built.
  - HELD_CYCLES and REPEAT_CYCLES are accepted but ignored.
  - Only releases increment, regardless of hold length.

## Test plan
- Reset then idle: hold i_Rst 3 cycles, release it, i_Switch=0 for 10 cycles -> o_Count=8'h00, both segment outputs 1000000, o_Wrap never set.
- Single release: i_Switch high 5 cycles, then low -> o_Count=8'h01 at the sampling edge; o_Seg_Ones=1111001 one cycle later; o_Seg_Tens=1000000.
- Decade carry and wrap:
  - 9 presses -> o_Count=8'h09, ones=0010000.
  - 10th press -> 8'h10.
  - With MAX_COUNT=12, the 13th press -> 8'h00 with a one-cycle o_Wrap.
- Auto-repeat, macro defined, HOLD_CYCLES=20, REPEAT_CYCLES=5: hold i_Switch high 35 cycles, then release -> increments at hold cycles 20, 25, 30, 35 (count 04); the release adds nothing.
- Same stimulus with the macro undefined -> count 01, taken on the release only.
- Reset mid-hold: in REPEAT, assert i_Rst in the same cycle as a timer expiry -> count 00, state IDLE, no o_Wrap. After deassertion with i_Switch still high, the block enters HELD and the timer restarts from 0.
